// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - Load/store sequencer between the CPU datapath and a word-only big-endian memory
//
// Purpose:
//   Accepts byte/halfword/word loads and stores from the CPU. Loads read the
//   containing word and extract the addressed big-endian lane with sign or
//   zero extension. Sub-word stores do read-modify-write. Every address is
//   range-checked against two 256-byte regions. Out-of-map requests fault
//   without touching memory.
//
// Optional feature (macro MEMCTL_MISALIGN_TRAP_EN):
//   Defined   - a misaligned halfword or word request faults with code 01.
//   Undefined - misaligned requests are force-aligned and complete normally.
//
// Parameters:
//   WAIT_CYCLES  - cycles mem_read is held before mem_data is sampled (1..15)
//   REGION0_BASE - base of the first mapped 256-byte region
//   REGION1_BASE - base of the second mapped 256-byte region
//
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-high reset
//   req_valid/ready   - CPU request handshake; ready only while idle
//   req_write         - 1 = store, 0 = load
//   req_size          - 00 byte, 01 halfword, 10/11 word
//   req_unsigned      - zero-extend loads
//   req_addr          - byte address
//   req_wdata         - store data, right-justified
//   resp_valid        - one-cycle completion pulse
//   resp_rdata        - extended load data (0 for stores and faults)
//   resp_fault        - request rejected
//   resp_fault_code   - 01 misaligned, 10 out of range, 00 none
//   mem_address       - word-aligned memory address
//   mem_write_data    - word written to memory
//   mem_read          - memory read strobe
//   mem_write         - memory write strobe
//   mem_data          - memory read data
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter logic [31:0] REGION0_BASE = 32'h0000_0000,
  parameter logic [31:0] REGION1_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_code,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_RANGE    = 2'b10;

  logic [2:0]  state;
  logic [3:0]  waitCnt;

  // Request fields captured at accept; the CPU may change its inputs afterwards.
  logic        opWrite;
  logic [1:0]  opSize;
  logic        opUnsigned;
  logic [1:0]  opOffset;
  logic [15:0] opWdata;

  logic [31:0] sampleWord;
  logic [31:0] rdataReg;
  logic        faultReg;
  logic [1:0]  faultCodeReg;

  logic        isHalfReq;
  logic        isWordReq;
  logic        inRange;
  logic        misaligned;
  logic [1:0]  effOffset;

  // Extract the addressed big-endian lane and extend it to 32 bits.
  function automatic logic [31:0] extractLoad(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  offset,
    input logic        zeroExt
  );
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    case (offset)
      2'd0:    laneByte = word[31:24];
      2'd1:    laneByte = word[23:16];
      2'd2:    laneByte = word[15:8];
      default: laneByte = word[7:0];
    endcase
    laneHalf = offset[1] ? word[15:0] : word[31:16];
    if (size[1]) begin
      extractLoad = word;
    end else if (size[0]) begin
      extractLoad = {{16{laneHalf[15] & ~zeroExt}}, laneHalf};
    end else begin
      extractLoad = {{24{laneByte[7] & ~zeroExt}}, laneByte};
    end
  endfunction

  // Replace only the addressed lane of the sampled word with store data.
  function automatic logic [31:0] mergeLane(
    input logic [31:0] word,
    input logic        isHalf,
    input logic [1:0]  offset,
    input logic [15:0] wdata
  );
    mergeLane = word;
    if (isHalf) begin
      if (offset[1]) mergeLane[15:0]  = wdata;
      else           mergeLane[31:16] = wdata;
    end else begin
      case (offset)
        2'd0:    mergeLane[31:24] = wdata[7:0];
        2'd1:    mergeLane[23:16] = wdata[7:0];
        2'd2:    mergeLane[15:8]  = wdata[7:0];
        default: mergeLane[7:0]   = wdata[7:0];
      endcase
    end
  endfunction

  assign isHalfReq = (req_size == 2'b01);
  assign isWordReq = req_size[1];

  assign inRange = (req_addr[31:8] == REGION0_BASE[31:8]) ||
                   (req_addr[31:8] == REGION1_BASE[31:8]);

`ifdef MEMCTL_MISALIGN_TRAP_EN
  assign misaligned = (isHalfReq && req_addr[0]) ||
                      (isWordReq && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane offset after force-alignment: halfwords drop bit 0, words drop both.
  always_comb begin
    effOffset = req_addr[1:0];
    if (isWordReq) begin
      effOffset = 2'b00;
    end else if (isHalfReq) begin
      effOffset[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      waitCnt        <= 4'd0;
      opWrite        <= 1'b0;
      opSize         <= 2'b00;
      opUnsigned     <= 1'b0;
      opOffset       <= 2'b00;
      opWdata        <= 16'h0000;
      sampleWord     <= 32'h0;
      rdataReg       <= 32'h0;
      faultReg       <= 1'b0;
      faultCodeReg   <= CODE_NONE;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opWrite      <= req_write;
            opSize       <= req_size;
            opUnsigned   <= req_unsigned;
            opOffset     <= effOffset;
            opWdata      <= req_wdata[15:0];
            rdataReg     <= 32'h0;
            faultReg     <= 1'b0;
            faultCodeReg <= CODE_NONE;
            waitCnt      <= 4'd0;
            // Range is tested first so an unmapped, misaligned address reports range.
            if (!inRange) begin
              faultReg     <= 1'b1;
              faultCodeReg <= CODE_RANGE;
              state        <= RESP;
            end else if (misaligned) begin
              faultReg     <= 1'b1;
              faultCodeReg <= CODE_MISALIGN;
              state        <= RESP;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              if (req_write && isWordReq) begin
                mem_write_data <= req_wdata;
                state          <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end

        RD: begin
          if (waitCnt == LAST_WAIT) begin
            if (opWrite) begin
              sampleWord <= mem_data;
              state      <= MERGE;
            end else begin
              rdataReg <= extractLoad(mem_data, opSize, opOffset, opUnsigned);
              state    <= RESP;
            end
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end

        // Strobe-free cycle between the read and the write of a read-modify-write.
        MERGE: begin
          mem_write_data <= mergeLane(sampleWord, opSize[0], opOffset, opWdata);
          state          <= WR;
        end

        WR: begin
          state <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign req_ready       = (state == IDLE);
  assign resp_valid      = (state == RESP);
  assign mem_read        = (state == RD);
  assign mem_write       = (state == WR);
  assign resp_rdata      = resp_valid ? rdataReg : 32'h0;
  assign resp_fault      = resp_valid & faultReg;
  assign resp_fault_code = resp_valid ? faultCodeReg : CODE_NONE;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - Self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int W = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  resp_fault_code;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data;

  int nChecks = 0;
  int nFails  = 0;

  mem_access_unit #(
    .WAIT_CYCLES (W),
    .REGION0_BASE(32'h0000_0000),
    .REGION1_BASE(32'h8000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .resp_fault_code(resp_fault_code),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_data       (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: a flat big-endian byte array, region bit then byte offset.
  logic [7:0] refBytes [0:511];

  function automatic logic [31:0] refWord(input int i);
    return {refBytes[4*i], refBytes[4*i+1], refBytes[4*i+2], refBytes[4*i+3]};
  endfunction

  // Word-only memory seen by the DUT.
  logic [31:0] memWords [0:127];
  logic        loadMem;

  assign mem_data = memWords[{mem_address[31], mem_address[7:2]}];

  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 128; i++) memWords[i] <= refWord(i);
    end else if (mem_write) begin
      memWords[{mem_address[31], mem_address[7:2]}] <= mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int startIdx(input logic [31:0] addr, input logic [1:0] sz);
    int n;
    n = nBytes(sz);
    return int'({addr[31], addr[7:0]}) / n * n;
  endfunction

  function automatic logic [1:0] modelCode(input logic [1:0] sz, input logic [31:0] addr);
    if (addr[31:8] != 24'h000000 && addr[31:8] != 24'h800000) return 2'b10;
`ifdef MEMCTL_MISALIGN_TRAP_EN
    if (addr % nBytes(sz) != 0) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    int n, s;
    logic [31:0] v;
    n = nBytes(sz);
    s = startIdx(addr, sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(refBytes[s+i]);
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wdata);
    int n, s;
    n = nBytes(sz);
    s = startIdx(addr, sz);
    for (int i = 0; i < n; i++) refBytes[s+i] = wdata[8*(n-1-i) +: 8];
  endtask

  task automatic expTiming(input logic wr, input logic [1:0] sz, input logic flt,
                           output int lat, output int rdN, output int wrC);
    if (flt)          begin lat = 1;     rdN = 0; wrC = 0;     end
    else if (!wr)     begin lat = W + 1; rdN = W; wrC = 0;     end
    else if (sz[1])   begin lat = 2;     rdN = 0; wrC = 1;     end
    else              begin lat = W + 3; rdN = W; wrC = W + 2; end
  endtask

  task automatic runTxn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic eFault, input logic [1:0] eCode, input logic [31:0] eRdata);
    int lat, rdExp, wrExp, cyc, rdCnt, rdFirst, rdLast, wrCnt, wrCyc;
    logic got, both, addrBad, readyInResp, f;
    logic [1:0] c;
    logic [31:0] rd, expWordAddr;
    expTiming(wr, sz, eFault, lat, rdExp, wrExp);
    expWordAddr = {addr[31:2], 2'b00};
    check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    cyc = 1; got = 1'b0; rdCnt = 0; rdFirst = 0; rdLast = 0; wrCnt = 0; wrCyc = 0;
    both = 1'b0; addrBad = 1'b0; readyInResp = 1'b1; f = 1'b0; c = 2'b00; rd = 32'h0;
    while (!got && cyc <= 40) begin
      if (mem_read) begin rdCnt++; if (rdFirst == 0) rdFirst = cyc; rdLast = cyc; end
      if (mem_write) begin wrCnt++; wrCyc = cyc; end
      if (mem_read && mem_write) both = 1'b1;
      if ((mem_read || mem_write) && mem_address != expWordAddr) addrBad = 1'b1;
      if (resp_valid) begin
        got = 1'b1; rd = resp_rdata; f = resp_fault; c = resp_fault_code;
        readyInResp = req_ready; req_valid = 1'b0;
      end else begin
        // Junk on the request bus while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom & 32'h8000_00FF; req_wdata = $urandom;
        @(posedge clk); #1; cyc++;
      end
    end
    req_valid = 1'b0;
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_fault"}, 32'(f), 32'(eFault));
    check({tag, "_code"}, 32'(c), 32'(eCode));
    check({tag, "_rdata"}, rd, eRdata);
    check({tag, "_rd_cycles"}, 32'(rdCnt), 32'(rdExp));
    check({tag, "_rd_first"}, 32'(rdFirst), (rdExp > 0) ? 32'd1 : 32'd0);
    check({tag, "_rd_last"}, 32'(rdLast), 32'(rdExp));
    check({tag, "_wr_count"}, 32'(wrCnt), (wrExp > 0) ? 32'd1 : 32'd0);
    check({tag, "_wr_cycle"}, 32'(wrCyc), 32'(wrExp));
    check({tag, "_strobe_overlap"}, 32'(both), 32'd0);
    check({tag, "_strobe_addr"}, 32'(addrBad), 32'd0);
    check({tag, "_ready_in_resp"}, 32'(readyInResp), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    if (rdExp > 0 || wrExp > 0) check({tag, "_addr_hold"}, mem_address, expWordAddr);
    if (wr && sz[1] && !eFault) check({tag, "_wdata_hold"}, mem_write_data, wdata);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [1:0]  code;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] code, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.fault = (code != 2'b00); v.code = code; v.rdata = rdata;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [1:0]  sz, code;
    logic [31:0] addr, wdata, exp;
    logic        wr, uns;
    int          pick;

    reset = 1'b1; loadMem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 512; i++) refBytes[i] = 8'($urandom);

    @(posedge clk); #1;
    loadMem = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_resp_fault", 32'(resp_fault), 32'd0);
    check("reset_fault_code", 32'(resp_fault_code), 32'd0);
    check("reset_mem_address", mem_address, 32'h0);
    check("reset_mem_write_data", mem_write_data, 32'h0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: {write, size, unsigned, addr, wdata} -> {code, rdata}.
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0010, 32'hDEADBEEF, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,        2'b00, 32'hDEADBEEF));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0010, 32'h11223344, 2'b00, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0011, 32'hFFFFFF5A, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,        2'b00, 32'h115A3344));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0010, 32'h12345680, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0013, 32'h0,        2'b00, 32'hFFFFFF80));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0013, 32'h0,        2'b00, 32'h00000080));
    vecs.push_back(mk(1, 2'b10, 0, 32'h8000_0000, 32'hAAAA7F01, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h8000_0002, 32'h0,        2'b00, 32'h00007F01));
    vecs.push_back(mk(0, 2'b01, 0, 32'h8000_0000, 32'h0,        2'b00, 32'hFFFFAAAA));
    vecs.push_back(mk(0, 2'b01, 1, 32'h8000_0000, 32'h0,        2'b00, 32'h0000AAAA));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0100, 32'h0,        2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0103, 32'h0,        2'b10, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h7FFF_FFFC, 32'h1,        2'b10, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0000, 32'hCAFEF00D, 2'b00, 32'h0));
`ifdef MEMCTL_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0002, 32'h0,        2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0003, 32'h0,        2'b01, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0081, 32'hABCD,     2'b01, 32'h0));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0002, 32'h0,        2'b00, 32'hCAFEF00D));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0003, 32'h0,        2'b00, 32'hFFFFF00D));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0081, 32'hABCD,     2'b00, 32'h0));
`endif
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0012, 32'h0000BEEF, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h0000_0010, 32'h0,        2'b00, 32'h1234BEEF));
    vecs.push_back(mk(1, 2'b00, 0, 32'h8000_0000, 32'h77,       2'b00, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h8000_0003, 32'h66,       2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h8000_0000, 32'h0,        2'b00, 32'h77AA7F66));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_00FF, 32'h11,       2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_00FF, 32'h0,        2'b00, 32'h00000011));

    foreach (vecs[i]) begin
      runTxn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, vecs[i].fault, vecs[i].code, vecs[i].rdata);
      if (vecs[i].wr && !vecs[i].fault) refStore(vecs[i].addr, vecs[i].sz, vecs[i].wdata);
    end

    // Reset asserted while a sub-word store is in its read phase.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = {24'h0, ~refBytes[32]};
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_rd_active", 32'(mem_read), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mem_read_drop", 32'(mem_read), 32'd0);
    check("rst_mem_write_low", 32'(mem_write), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (W + 5) @(posedge clk);
    #1;
    check("rst_mem_unchanged", memWords[8], refWord(8));
    check("rst_ready_after", 32'(req_ready), 32'd1);

    // Randomized traffic against the byte-array reference model.
    for (int t = 0; t < 150; t++) begin
      wr = 1'($urandom);
      sz = 2'($urandom);
      uns = 1'($urandom);
      wdata = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 4)      addr = {24'h000000, 8'($urandom)};
      else if (pick < 8) addr = {24'h800000, 8'($urandom)};
      else               addr = {8'h40, 24'($urandom)};
      code = modelCode(sz, addr);
      exp = (wr || code != 2'b00) ? 32'h0 : refLoad(addr, sz, uns);
      runTxn($sformatf("rnd%0d", t), wr, sz, uns, addr, wdata, code != 2'b00, code, exp);
      if (wr && code == 2'b00) refStore(addr, sz, wdata);
    end

    for (int i = 0; i < 128; i++) check($sformatf("mem_word%0d", i), memWords[i], refWord(i));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
